// File: rtl/router_pkg.sv
// router_pkg: shared constants, port-address type and one-hot decode helper for router_sync.
package router_pkg;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W = 2;
  localparam int TIMEOUT_DEFAULT = 30;
  typedef logic [ADDR_W-1:0] port_addr_t;
  localparam port_addr_t ADDR_INVALID = 2'b11;
  function automatic logic [NUM_PORTS-1:0] port_onehot(port_addr_t a);
    return a == ADDR_INVALID ? '0 : NUM_PORTS'(1) << a;
  endfunction
endpackage

// File: rtl/router_sync_if.sv
// router_sync_if: FSM/FIFO/destination-side signals of router_sync.
//   slave  (router_sync): detect_add, d_in, wr_en_reg, read_en_x, empty_x, full_x in;
//                          fifo_full, vld_out_x, write_enb, soft_rst_x, addr_err out.
//   master (environment): the mirror image.
interface router_sync_if;
  import router_pkg::*;
  logic detect_add;
  port_addr_t d_in;
  logic wr_en_reg;
  logic read_en_0, read_en_1, read_en_2;
  logic empty_0, empty_1, empty_2;
  logic full_0, full_1, full_2;
  logic fifo_full;
  logic vld_out_0, vld_out_1, vld_out_2;
  logic [NUM_PORTS-1:0] write_enb;
  logic soft_rst_0, soft_rst_1, soft_rst_2;
  logic addr_err;
  modport slave (
    input detect_add, d_in, wr_en_reg, read_en_0, read_en_1, read_en_2,
          empty_0, empty_1, empty_2, full_0, full_1, full_2,
    output fifo_full, vld_out_0, vld_out_1, vld_out_2, write_enb,
           soft_rst_0, soft_rst_1, soft_rst_2, addr_err
  );
  modport master (
    output detect_add, d_in, wr_en_reg, read_en_0, read_en_1, read_en_2,
           empty_0, empty_1, empty_2, full_0, full_1, full_2,
    input fifo_full, vld_out_0, vld_out_1, vld_out_2, write_enb,
          soft_rst_0, soft_rst_1, soft_rst_2, addr_err
  );
endinterface

// File: rtl/router_sync_timer.sv
// router_sync_timer: per-port unread-data watchdog; pulses soft_rst for one cycle after
//   TIMEOUT consecutive cycles of cond (valid and not read).
//   clk, rst (async, active-low), cond in; soft_rst out.
module router_sync_timer #(
  parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic cond,
  output logic soft_rst
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic soft_rst_q, soft_rst_d;
  always_comb begin
    soft_rst_d = cond && cnt_q == LAST;
    // the pulse cycle itself is never counted, so the next window starts afterwards
    cnt_d = (soft_rst_q || !cond || soft_rst_d) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      soft_rst_q <= soft_rst_d;
    end
  assign soft_rst = soft_rst_q;
endmodule

// File: rtl/router_sync.sv
// router_sync: address latch, FIFO write steering, full-flag select, vld_out and per-port
//   timeout soft resets for the 1x3 router.
//   clk, rst (async, active-low); bus (router_sync_if.slave) carries all handshake signals.
//   ROUTER_ADDR_ERR_EN: when defined, addr_err flags a header carrying address 2'b11;
//   otherwise addr_err is tied low.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  router_sync_if.slave bus
);
  port_addr_t addr_q, addr_d;
  logic [NUM_PORTS-1:0] full_v, vld, cond, soft_rst;
  always_comb begin
    addr_d = bus.detect_add ? bus.d_in : addr_q;
    full_v = {bus.full_2, bus.full_1, bus.full_0};
    vld = ~{bus.empty_2, bus.empty_1, bus.empty_0};
    cond = vld & ~{bus.read_en_2, bus.read_en_1, bus.read_en_0};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) addr_q <= '0;
    else addr_q <= addr_d;
  assign bus.write_enb = bus.wr_en_reg ? port_onehot(addr_q) : '0;
  assign bus.fifo_full = |(full_v & port_onehot(addr_q));
  assign bus.vld_out_0 = vld[0];
  assign bus.vld_out_1 = vld[1];
  assign bus.vld_out_2 = vld[2];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tmr
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clk(clk),
      .rst(rst),
      .cond(cond[i]),
      .soft_rst(soft_rst[i])
    );
  end
  assign bus.soft_rst_0 = soft_rst[0];
  assign bus.soft_rst_1 = soft_rst[1];
  assign bus.soft_rst_2 = soft_rst[2];
`ifdef ROUTER_ADDR_ERR_EN
  logic addr_err_q, addr_err_d;
  always_comb addr_err_d = bus.detect_add ? bus.d_in == ADDR_INVALID : addr_err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) addr_err_q <= 1'b0;
    else addr_err_q <= addr_err_d;
  assign bus.addr_err = addr_err_q;
`else
  assign bus.addr_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: directed scenarios plus randomized traffic against a behavioural model.
module tb_router_sync;
  import router_pkg::*;
  localparam int T = TIMEOUT_DEFAULT;
`ifdef ROUTER_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic det = 1'b0, wr = 1'b0;
  logic [1:0] din = 2'b00;
  logic [2:0] rd = 3'b000, emp = 3'b111, full = 3'b000;
  int total = 0, bad = 0;
  router_sync_if bus();
  assign bus.detect_add = det;
  assign bus.d_in = din;
  assign bus.wr_en_reg = wr;
  assign bus.read_en_0 = rd[0];
  assign bus.read_en_1 = rd[1];
  assign bus.read_en_2 = rd[2];
  assign bus.empty_0 = emp[0];
  assign bus.empty_1 = emp[1];
  assign bus.empty_2 = emp[2];
  assign bus.full_0 = full[0];
  assign bus.full_1 = full[1];
  assign bus.full_2 = full[2];
  router_sync #(.TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  wire [2:0] sr = {bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0};
  wire [2:0] vld = {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
  wire [10:0] obs = {sr, vld, bus.write_enb, bus.fifo_full, bus.addr_err};
  // Model: run[p] = qualifying edges seen in the current window; a pulse ends the window
  // and the edge that closes the pulse cycle is ignored.
  int m_addr = 0;
  bit m_err = 1'b0;
  int m_run[3] = '{0, 0, 0};
  bit [2:0] m_pulse = 3'b000;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_addr <= 0;
      m_err <= 1'b0;
      m_pulse <= 3'b000;
      for (int p = 0; p < 3; p++) m_run[p] <= 0;
    end else begin
      if (det) begin
        m_addr <= int'(din);
        if (ERR_EN) m_err <= (din == 2'd3);
      end
      for (int p = 0; p < 3; p++)
        if (m_pulse[p]) begin
          m_pulse[p] <= 1'b0;
          m_run[p] <= 0;
        end else if (!emp[p] && !rd[p]) begin
          if (m_run[p] + 1 == T) begin
            m_pulse[p] <= 1'b1;
            m_run[p] <= 0;
          end else m_run[p] <= m_run[p] + 1;
        end else m_run[p] <= 0;
    end
  function automatic logic [10:0] expv();
    logic [2:0] we;
    logic ff;
    we = (wr && m_addr < 3) ? 3'(1 << m_addr) : 3'b000;
    ff = (m_addr < 3) ? full[m_addr] : 1'b0;
    return {m_pulse, ~emp, we, ff, m_err};
  endfunction
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    wr = 1'b1;
    full = 3'b001;
    #1;
    if (bus.write_enb !== 3'b001 || sr !== 3'b000 || bus.addr_err !== 1'b0 || bus.fifo_full !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got we=%b sr=%b err=%b ff=%b want we=001 sr=000 err=0 ff=1",
               bus.write_enb, sr, bus.addr_err, bus.fifo_full);
    end
    total++;
    @(negedge clk);
    rst = 1'b1;
    wr = 1'b0;
    full = 3'b000;
  endtask
  task automatic test_mid_reset();
    det = 1'b1;
    din = 2'd2;
    cycle();
    det = 1'b0;
    wr = 1'b1;
    emp = 3'b101;
    for (int k = 0; k < 10; k++) cycle();
    if (obs !== expv()) begin
      bad++;
      $display("FAIL midrst_pre got=%b want=%b", obs, expv());
    end
    total++;
    #2 rst = 1'b0;
    #1;
    if (bus.write_enb !== 3'b001 || sr !== 3'b000) begin
      bad++;
      $display("FAIL midrst_async got we=%b sr=%b want we=001 sr=000", bus.write_enb, sr);
    end
    total++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= T + 1; k++) begin
      cycle();
      if (bus.soft_rst_1 !== (k == T) || obs !== expv()) begin
        bad++;
        $display("FAIL midrst_recount k=%0d got sr=%b obs=%b want sr1=%0d obs=%b", k, sr, obs, k == T, expv());
      end
      total++;
    end
    emp = 3'b111;
    wr = 1'b0;
    cycle();
  endtask
  task automatic test_addr_full();
    det = 1'b1;
    din = 2'd1;
    cycle();
    det = 1'b0;
    wr = 1'b1;
    #1;
    if (bus.write_enb !== 3'b010) begin
      bad++;
      $display("FAIL addr_we got=%b want=010", bus.write_enb);
    end
    total++;
    full = 3'b010;
    #1;
    if (bus.fifo_full !== 1'b1) begin
      bad++;
      $display("FAIL full_sel1 got=%b want=1", bus.fifo_full);
    end
    total++;
    full = 3'b001;
    #1;
    if (bus.fifo_full !== 1'b0) begin
      bad++;
      $display("FAIL full_other got=%b want=0", bus.fifo_full);
    end
    total++;
    wr = 1'b0;
    full = 3'b000;
    cycle();
  endtask
  task automatic test_timeout();
    emp = 3'b011;
    for (int k = 1; k <= T + 2; k++) begin
      cycle();
      if (sr !== ((k == T) ? 3'b100 : 3'b000) || obs !== expv()) begin
        bad++;
        $display("FAIL timeout2 k=%0d got sr=%b obs=%b want sr=%b obs=%b", k, sr, obs,
                 (k == T) ? 3'b100 : 3'b000, expv());
      end
      total++;
    end
    emp = 3'b111;
    cycle();
  endtask
  task automatic test_read_restart();
    emp = 3'b110;
    for (int k = 1; k <= T - 2; k++) cycle();
    rd[0] = 1'b1;
    cycle();
    rd[0] = 1'b0;
    if (sr !== 3'b000) begin
      bad++;
      $display("FAIL read_nopulse got sr=%b want 000", sr);
    end
    total++;
    for (int k = 1; k <= T + 1; k++) begin
      cycle();
      if (bus.soft_rst_0 !== (k == T) || obs !== expv()) begin
        bad++;
        $display("FAIL read_restart k=%0d got sr=%b want sr0=%0d", k, sr, k == T);
      end
      total++;
    end
    emp = 3'b111;
    cycle();
  endtask
  task automatic test_bad_addr();
    full = 3'b111;
    det = 1'b1;
    din = 2'd3;
    cycle();
    det = 1'b0;
    wr = 1'b1;
    #1;
    if (bus.write_enb !== 3'b000 || bus.fifo_full !== 1'b0 || bus.addr_err !== ERR_EN) begin
      bad++;
      $display("FAIL bad_addr got we=%b ff=%b err=%b want we=000 ff=0 err=%b",
               bus.write_enb, bus.fifo_full, bus.addr_err, ERR_EN);
    end
    total++;
    det = 1'b1;
    din = 2'd0;
    cycle();
    det = 1'b0;
    #1;
    if (bus.addr_err !== 1'b0 || bus.write_enb !== 3'b001) begin
      bad++;
      $display("FAIL addr_err_clear got err=%b we=%b want err=0 we=001", bus.addr_err, bus.write_enb);
    end
    total++;
    wr = 1'b0;
    full = 3'b000;
    cycle();
  endtask
  task automatic test_same_cycle();
    det = 1'b1;
    din = 2'd2;
    cycle();
    din = 2'd0;
    wr = 1'b1;
    #1;
    if (bus.write_enb !== 3'b100) begin
      bad++;
      $display("FAIL same_cycle_old got=%b want=100", bus.write_enb);
    end
    total++;
    cycle();
    det = 1'b0;
    #1;
    if (bus.write_enb !== 3'b001) begin
      bad++;
      $display("FAIL same_cycle_new got=%b want=001", bus.write_enb);
    end
    total++;
    wr = 1'b0;
    cycle();
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      det = ($urandom_range(0, 3) == 0);
      din = 2'($urandom_range(0, 3));
      wr = 1'($urandom);
      full = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        rd[p] = ($urandom_range(0, 39) == 0);
        emp[p] = ($urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b0;
        #1 rst = 1'b1;
      end
      #1;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random n=%0d got=%b want=%b", n, obs, expv());
      end
      total++;
      cycle();
    end
  endtask
  initial begin
    rst = 1'b0;
    #2;
    test_reset();
    test_mid_reset();
    test_addr_full();
    test_timeout();
    test_read_restart();
    test_bad_addr();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
